counter_run_controller: RTL and testbench
=========================================

Name: counter_run_controller

Overview:
- Sequencer/arbiter that shares one 4-bit synchronous counter (four_bit_Synchronous_Counter datapath) between two requesters.
- Per job: selects a requester, clears the counter, enables counting for a requested number of clocks, then holds the result and pulses done.
- Sits between requester logic and the counter. Drives the counter's cnt_en and clear; observes its q.

Parameters:
- CNT_W, 4, counter width; len and cnt_q widths; run length 0 encodes 2^CNT_W.
- NUM_REQ, 2, requester count; fixed at 2 in this revision.

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- clear  input  1  reset, synchronous, active-low.
- req  input  2  per-requester job request; level, held until done or deliberately dropped (abort).
- len0  input  CNT_W  run length for requester 0; sampled at grant.
- len1  input  CNT_W  run length for requester 1; sampled at grant.
- gnt  output  2  one-hot grant; high while the owner's job is in RUN.
- done  output  2  one-cycle completion pulse to the owner.
- busy  output  1  controller not IDLE.
- cnt_en  output  1  to counter cnt_en.
- cnt_clear  output  1  to counter clear, active-low.
- cnt_q  input  CNT_W  counter q.

Behaviour:
- Reset (clear=0 at an edge):
  - state=IDLE, len_reg=0, owner=0, rr pointer=1.
  - gnt=00, done=00, busy=0, cnt_en=0, cnt_clear=0.
- All outputs are Moore-decoded from registered state.
- States IDLE, RUN, DONE.
- IDLE:
  - cnt_clear=0, so the counter is held at 0.
  - If any req is high, select the owner, latch len_reg from that requester's len, and go to RUN next cycle.
  - If no req is high, stay.
- RUN:
  - gnt[owner]=1, cnt_en=1, cnt_clear=1, busy=1.
  - If req[owner]=0: abort. Next state IDLE, no done pulse; the counter is cleared by IDLE.
  - Else if cnt_q == len_reg-1 (mod 2^CNT_W): next state DONE.
- DONE:
  - done[owner]=1 for exactly one cycle; gnt=00, cnt_en=0, cnt_clear=1.
  - Counter holds len mod 2^CNT_W so the owner can read cnt_q.
  - Next state IDLE unconditionally; no grant is issued from DONE.
- Timing:
  - req sampled in IDLE at edge n gives RUN from cycle n+1 for exactly L cycles (L=len, or 16 if len=0), then DONE for 1 cycle, then IDLE.
  - Minimum job-to-job gap: DONE plus one IDLE cycle.
- Simultaneous events:
  - Both req high in IDLE: arbitration per the optional feature.
  - Non-owner req is ignored until the next IDLE.
  - Changes to len during RUN are ignored.
- Owner still asserting req after done: it is re-arbitrated as a new job.
- Reset mid-RUN: immediate return to reset values at that edge, no done pulse.

Optional Feature:
- Macro CRC_ROUND_ROBIN_EN.
- Defined:
  - Two-way round-robin.
  - On contention, grant the requester other than the last owner.
  - The rr pointer updates on every grant; the reset pointer makes req0 win the first contention.
  - Aborted jobs also update the pointer.
- Undefined:
  - Fixed priority, req0 always wins contention.
  - rr pointer logic absent.

Decomposition:
- Package counter_run_pkg:
  - state enum (IDLE, RUN, DONE), CNT_W default, NUM_REQ.
  - Function for the terminal compare (len_reg-1 wrap).
- One sub-module: rr_arbiter2.
  - Inputs: req[1:0], last owner, update strobe.
  - Outputs: one-hot grant.
  - Its round-robin body is compiled under CRC_ROUND_ROBIN_EN; otherwise it reduces to fixed priority.

Test Plan:
- Reset then idle → gnt=00, done=00, busy=0, cnt_en=0, cnt_clear=0; counter q=0.
- req0=1, len0=5 → gnt=01 for 5 cycles, cnt_en high 5 cycles, done=01 one cycle with cnt_q=5, then busy=0 and q cleared to 0.
- req1=1, len1=0 → 16 RUN cycles, done=10, cnt_q=0 (wrapped); len1=1 → 1 RUN cycle, cnt_q=1.
- Both req high continuously, len0=3, len1=2:
  - With CRC_ROUND_ROBIN_EN, grants alternate 0,1,0.
  - Without it, owner is always 0.
- req0 dropped on the third RUN cycle, len0=8 → next cycle IDLE, no done pulse, counter cleared, req1 then granted.
- clear pulsed low mid-RUN → all outputs at reset values next cycle, no done.

Source files
------------

// File: rtl/counter_run_pkg.sv
// Shared types and helpers for the counter run controller.
package counter_run_pkg;

   localparam int unsigned CNT_W_DFLT = 4;
   localparam int unsigned NUM_REQ    = 2;
   localparam int unsigned CNT_W_MAX  = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // True when q is the final count of a run of length len (q == len-1 mod 2^w);
   // len == 0 therefore ends on the all-ones count, giving a full 2^w run.
   function automatic logic last_count(input logic [CNT_W_MAX-1:0] q,
                                       input logic [CNT_W_MAX-1:0] len,
                                       input int unsigned          w);
      logic [CNT_W_MAX-1:0] mask;
      logic [CNT_W_MAX-1:0] diff;
      mask = (CNT_W_MAX'(1) << w) - CNT_W_MAX'(1);
      diff = len - q - CNT_W_MAX'(1);
      return (diff & mask) == '0;
   endfunction

endpackage

// File: rtl/counter_run_controller_rr_arbiter2.sv
// Two-way request arbiter; round-robin when CRC_ROUND_ROBIN_EN is defined,
// otherwise fixed priority with req[0] winning contention.
module rr_arbiter2
   import counter_run_pkg::*;
(
   input  logic               clock,
   input  logic               clear,
   input  logic [NUM_REQ-1:0] req,
   input  logic               last_owner,
   input  logic               upd,
   output logic [NUM_REQ-1:0] gnt_c
);

`ifdef CRC_ROUND_ROBIN_EN
   logic ptr_q;
   logic ptr_d;

   // Pointer remembers the most recent owner; reset value lets req[0] win first.
   always_ff @(posedge clock) begin
      if (!clear) begin
         ptr_q <= 1'b1;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (upd) begin
         ptr_d = last_owner;
      end
   end

   always_comb begin
      gnt_c = '0;
      if (req == 2'b11) begin
         gnt_c[~ptr_q] = 1'b1;
      end else if (req[0]) begin
         gnt_c = 2'b01;
      end else if (req[1]) begin
         gnt_c = 2'b10;
      end
   end
`else
   logic unused_c;
   assign unused_c = ^{clock, clear, last_owner, upd};

   always_comb begin
      gnt_c = '0;
      if (req[0]) begin
         gnt_c = 2'b01;
      end else if (req[1]) begin
         gnt_c = 2'b10;
      end
   end
`endif

endmodule

// File: rtl/counter_run_controller.sv
// Shares one synchronous counter between two requesters: grant, clear, count
// for len cycles, hold result and pulse done. Arbitration policy: CRC_ROUND_ROBIN_EN.
module counter_run_controller
   import counter_run_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DFLT
)
(
   input  logic               clock,
   input  logic               clear,
   input  logic [NUM_REQ-1:0] req,
   input  logic [CNT_W-1:0]   len0,
   input  logic [CNT_W-1:0]   len1,
   output logic [NUM_REQ-1:0] gnt,
   output logic [NUM_REQ-1:0] done,
   output logic               busy,
   output logic               cnt_en,
   output logic               cnt_clear,
   input  logic [CNT_W-1:0]   cnt_q
);

   state_e             state_q, state_d;
   logic               owner_q, owner_d;
   logic [CNT_W-1:0]   len_q, len_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic               busy_q, busy_d;
   logic               cnt_en_q, cnt_en_d;
   logic               cnt_clear_q, cnt_clear_d;

   logic [NUM_REQ-1:0] arb_gnt_c;
   logic               upd_c;
   logic               last_c;

   assign upd_c  = (state_q == ST_IDLE) && (|req);
   assign last_c = last_count(CNT_W_MAX'(cnt_q), CNT_W_MAX'(len_q), CNT_W);

   rr_arbiter2 u_arb (
      .clock      (clock),
      .clear      (clear),
      .req        (req),
      .last_owner (owner_d),
      .upd        (upd_c),
      .gnt_c      (arb_gnt_c)
   );

   // State and registered Moore outputs.
   always_ff @(posedge clock) begin
      if (!clear) begin
         state_q     <= ST_IDLE;
         owner_q     <= 1'b0;
         len_q       <= '0;
         gnt_q       <= '0;
         done_q      <= '0;
         busy_q      <= 1'b0;
         cnt_en_q    <= 1'b0;
         cnt_clear_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         len_q       <= len_d;
         gnt_q       <= gnt_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         cnt_en_q    <= cnt_en_d;
         cnt_clear_q <= cnt_clear_d;
      end
   end

   // Next state, plus output values decoded from the state being entered.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      len_d       = len_q;
      gnt_d       = '0;
      done_d      = '0;
      busy_d      = 1'b0;
      cnt_en_d    = 1'b0;
      cnt_clear_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (|req) begin
               owner_d = arb_gnt_c[1];
               len_d   = arb_gnt_c[0] ? len0 : len1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!req[owner_q]) begin
               state_d = ST_IDLE;
            end else if (last_c) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d      = (state_d != ST_IDLE);
      cnt_clear_d = (state_d != ST_IDLE);
      cnt_en_d    = (state_d == ST_RUN);
      if (state_d == ST_RUN) begin
         gnt_d[owner_d] = 1'b1;
      end
      if (state_d == ST_DONE) begin
         done_d[owner_d] = 1'b1;
      end
   end

   assign gnt       = gnt_q;
   assign done      = done_q;
   assign busy      = busy_q;
   assign cnt_en    = cnt_en_q;
   assign cnt_clear = cnt_clear_q;

endmodule

// File: tb/tb_counter_run_controller.sv
// Directed bench for counter_run_controller driving a 4-bit counter model.
module tb_counter_run_controller;

   logic       clock;
   logic       clear;
   logic [1:0] req;
   logic [3:0] len0;
   logic [3:0] len1;
   logic [1:0] gnt;
   logic [1:0] done;
   logic       busy;
   logic       cnt_en;
   logic       cnt_clear;
   logic [3:0] cnt_q;

   int n_checks = 0;
   int n_pass   = 0;
   int own_seq[3];

   counter_run_controller dut (
      .clock     (clock),
      .clear     (clear),
      .req       (req),
      .len0      (len0),
      .len1      (len1),
      .gnt       (gnt),
      .done      (done),
      .busy      (busy),
      .cnt_en    (cnt_en),
      .cnt_clear (cnt_clear),
      .cnt_q     (cnt_q)
   );

   // Shared 4-bit synchronous counter with active-low clear.
   always_ff @(posedge clock) begin
      if (!cnt_clear) begin
         cnt_q <= '0;
      end else if (cnt_en) begin
         cnt_q <= cnt_q + 4'd1;
      end
   end

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic chk_out(input string tag, input logic [1:0] g, input logic [1:0] d,
                          input logic b, input logic en, input logic clr, input int q);
      check({tag, ".gnt"}, 32'(gnt), 32'(g));
      check({tag, ".done"}, 32'(done), 32'(d));
      check({tag, ".busy"}, 32'(busy), 32'(b));
      check({tag, ".cnt_en"}, 32'(cnt_en), 32'(en));
      check({tag, ".cnt_clear"}, 32'(cnt_clear), 32'(clr));
      check({tag, ".cnt_q"}, 32'(cnt_q), 32'(q));
   endtask

   initial begin
`ifdef CRC_ROUND_ROBIN_EN
      own_seq = '{0, 1, 0};
`else
      own_seq = '{0, 0, 0};
`endif
      clear = 1'b0;
      req   = 2'b00;
      len0  = 4'd0;
      len1  = 4'd0;
      repeat (3) tick();
      chk_out("reset", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 0);
      clear = 1'b1;
      tick();
      chk_out("idle", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 0);

      // Requester 0, length 5; len0 change during RUN must be ignored.
      req  = 2'b01;
      len0 = 4'd5;
      tick();
      len0 = 4'd9;
      for (int i = 0; i < 5; i++) begin
         chk_out("run_a", 2'b01, 2'b00, 1'b1, 1'b1, 1'b1, i);
         tick();
      end
      chk_out("done_a", 2'b00, 2'b01, 1'b1, 1'b0, 1'b1, 5);
      req = 2'b00;
      tick();
      chk_out("idle_a", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5);
      tick();
      check("clr_a", 32'(cnt_q), 32'd0);

      // Requester 1, length 0 means a full 16-cycle wrap.
      req  = 2'b10;
      len1 = 4'd0;
      tick();
      for (int i = 0; i < 16; i++) begin
         chk_out("run_b", 2'b10, 2'b00, 1'b1, 1'b1, 1'b1, i);
         tick();
      end
      chk_out("done_b", 2'b00, 2'b10, 1'b1, 1'b0, 1'b1, 0);
      len1 = 4'd1;
      tick();
      chk_out("rearb_idle", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 0);
      tick();
      chk_out("run_b1", 2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 0);
      tick();
      chk_out("done_b1", 2'b00, 2'b10, 1'b1, 1'b0, 1'b1, 1);
      req = 2'b00;
      tick();
      tick();

      // Continuous contention.
      req  = 2'b11;
      len0 = 4'd3;
      len1 = 4'd2;
      for (int k = 0; k < 3; k++) begin
         logic [1:0] g;
         int         len;
         g   = (own_seq[k] == 1) ? 2'b10 : 2'b01;
         len = (own_seq[k] == 1) ? 2 : 3;
         tick();
         for (int i = 0; i < len; i++) begin
            chk_out($sformatf("cont%0d", k), g, 2'b00, 1'b1, 1'b1, 1'b1, i);
            tick();
         end
         chk_out($sformatf("cont%0d_done", k), 2'b00, g, 1'b1, 1'b0, 1'b1, len);
         tick();
         check($sformatf("cont%0d_idle", k), 32'(busy), 32'd0);
      end
      req = 2'b00;
      tick();
      tick();

      // Abort: req0 dropped on third RUN cycle, then req1 gets the counter.
      len0 = 4'd8;
      len1 = 4'd2;
      req  = 2'b01;
      tick();
      chk_out("ab_run1", 2'b01, 2'b00, 1'b1, 1'b1, 1'b1, 0);
      req = 2'b11;
      tick();
      chk_out("ab_run2", 2'b01, 2'b00, 1'b1, 1'b1, 1'b1, 1);
      tick();
      chk_out("ab_run3", 2'b01, 2'b00, 1'b1, 1'b1, 1'b1, 2);
      req = 2'b10;
      tick();
      chk_out("ab_idle", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 3);
      tick();
      chk_out("ab_req1", 2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 0);
      tick();
      chk_out("ab_req1b", 2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 1);

      // Reset on the edge that would otherwise enter DONE.
      clear = 1'b0;
      tick();
      chk_out("mid_rst", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2);
      tick();
      chk_out("mid_rst2", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 0);
      clear = 1'b1;
      req   = 2'b00;
      tick();
      chk_out("post_rst", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
